// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ultrasonic ranger and its consumers: raw echo in,
// trigger pulse and published measurement out.
interface ultrasonic_ranger_if #(
    parameter int CNT_W = 32
) ();
    logic             echo;
    logic             trig;
    logic [CNT_W-1:0] echo_cnt;
    logic             echo_valid;
    logic             timeout;
    logic             near;

    // The ranger itself drives the measurement side.
    modport master (
        input  echo,
        output trig,
        output echo_cnt,
        output echo_valid,
        output timeout,
        output near
    );

    modport slave (
        output echo,
        input  trig,
        input  echo_cnt,
        input  echo_valid,
        input  timeout,
        input  near
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger front-end: periodic trigger, echo width measurement with
// timeouts, and a registered near-obstacle flag for the motor stage.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int NEAR_THRESH    = 1000,
    parameter int CNT_W          = 32
) (
    input  logic                osc,
    input  logic                reset_n,
    ultrasonic_ranger_if.master bus
);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] NEAR_VAL  = CNT_W'(NEAR_THRESH);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE
    } state_t;

    state_t           state;
    logic             echo_m;
    logic             echo_s;
    logic             echo_d;
    logic             echo_rise;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] width;
    logic             to_pend;

    always_ff @(posedge osc or negedge reset_n) begin
        if (!reset_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= bus.echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;

    always_ff @(posedge osc or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            per_cnt        <= PER_LAST;
            wait_cnt       <= '0;
            width          <= '0;
            to_pend        <= 1'b0;
            bus.trig       <= 1'b0;
            bus.echo_cnt   <= '0;
            bus.echo_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.near       <= 1'b0;
        end else begin
            bus.echo_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            if (per_cnt != PER_LAST) begin
                per_cnt <= per_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (per_cnt == PER_LAST) begin
                        state    <= TRIG;
                        bus.trig <= 1'b1;
                        per_cnt  <= '0;
                    end
                end
                // per_cnt restarted at trigger entry, so it doubles as the pulse timer.
                TRIG: begin
                    if (per_cnt == TRIG_LAST) begin
                        state    <= WAIT_RISE;
                        bus.trig <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        // The edge cycle already has echo_s high, so it counts as one.
                        width   <= CNT_W'(1);
                        to_pend <= 1'b0;
                        state   <= MEASURE;
                    end else if (wait_cnt == TO_LAST) begin
                        to_pend <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        to_pend <= 1'b0;
                        state   <= DONE;
                    end else if (width == TO_VAL) begin
                        to_pend <= 1'b1;
                        state   <= DONE;
                    end else begin
                        width <= width + 1'b1;
                    end
                end
                DONE: begin
                    bus.echo_valid <= 1'b1;
                    bus.timeout    <= to_pend;
                    bus.echo_cnt   <= to_pend ? TO_VAL : width;
                    bus.near       <= !to_pend && (width <= NEAR_VAL);
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
